branch_resolve_unit: RTL

- Execute-stage branch resolution unit; the consumer end of the fetch stage's static prediction.
- Fetch predicts taken for every JAL and conditional branch and falls through (pc+4) otherwise.
- This block evaluates each control-transfer instruction in EX and compares the true next-PC against the predicted address that travelled down the pipe.
- On a mismatch it drives the fetch redirect pair (branch_taken, branch_addr) and squashes wrong-path instructions. It also keeps branch and misprediction statistics.

---
 rtl/branch_resolve_unit.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Execute-stage branch resolution. Evaluates JAL, JALR and
//               conditional branches, compares the true next-PC with the
//               address fetch predicted, and on a mismatch issues a one-cycle
//               redirect plus a multi-cycle squash of the wrong-path IF/ID
//               instructions. Keeps saturating branch and mispredict counts.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-high reset
//   ex_valid_i       EX stage holds a live instruction
//   ex_pc_i          PC of the EX instruction
//   ex_pred_addr_i   next-PC predicted by fetch for this instruction
//   ex_is_jal_i      instruction is JAL
//   ex_is_jalr_i     instruction is JALR
//   ex_is_branch_i   instruction is a conditional branch
//   ex_funct3_i      branch condition code
//   ex_rs1_i         forwarded rs1 value
//   ex_rs2_i         forwarded rs2 value
//   ex_imm_i         sign-extended immediate
//   branch_taken_o   redirect strobe to fetch (one cycle per mispredict)
//   branch_addr_o    corrected fetch address, held between redirects
//   flush_o          squash IF/ID, high FLUSH_CYCLES cycles after a redirect
//   link_addr_o      registered pc+4 of the last accepted JAL/JALR
//   illegal_br_o     one-cycle pulse for a branch with reserved funct3
//   br_count_o       accepted control transfers (saturating)
//   mispred_count_o  redirects issued (saturating)
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_pred_addr_i,
  input  logic             ex_is_jal_i,
  input  logic             ex_is_jalr_i,
  input  logic             ex_is_branch_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [XLEN-1:0]  ex_rs1_i,
  input  logic [XLEN-1:0]  ex_rs2_i,
  input  logic [XLEN-1:0]  ex_imm_i,
  output logic             branch_taken_o,
  output logic [XLEN-1:0]  branch_addr_o,
  output logic             flush_o,
  output logic [XLEN-1:0]  link_addr_o,
  output logic             illegal_br_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  // FLUSH_CYCLES is at most 7, so a 3-bit down-counter covers it.
  localparam int         C_FC_W    = 3;
  localparam logic [2:0] C_FC_LOAD = C_FC_W'(FLUSH_CYCLES);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [C_FC_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic                taken_q, taken_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     link_q, link_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]    mis_cnt_q, mis_cnt_d;

  // --------------------------------------------------------------------------
  // Acceptance: live instruction, RUN state, exactly one control flag.
  // --------------------------------------------------------------------------
  logic [1:0] w_nflags;
  logic       w_onehot;
  logic       w_accept;

  assign w_nflags = {1'b0, ex_is_jal_i} + {1'b0, ex_is_jalr_i} + {1'b0, ex_is_branch_i};
  assign w_onehot = (w_nflags == 2'd1);
  assign w_accept = ex_valid_i && (state_q == ST_RUN) && w_onehot;

  // --------------------------------------------------------------------------
  // Branch condition evaluation.
  // --------------------------------------------------------------------------
  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;
  logic w_cond;
  logic w_reserved;

  assign w_eq   = (ex_rs1_i == ex_rs2_i);
  assign w_lt_s = ($signed(ex_rs1_i) < $signed(ex_rs2_i));
  assign w_lt_u = (ex_rs1_i < ex_rs2_i);

  always_comb begin
    w_cond     = 1'b0;
    w_reserved = 1'b0;
    case (ex_funct3_i)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt_s;
      3'b101:  w_cond = !w_lt_s;
      3'b110:  w_cond = w_lt_u;
      3'b111:  w_cond = !w_lt_u;
      3'b010,
      3'b011:  w_reserved = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // True next-PC. All sums wrap modulo 2^XLEN; misaligned targets pass through.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_pc_4;
  logic [XLEN-1:0] w_rs1_imm;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_next_pc;
  logic            w_mispred;

  assign w_pc_imm   = ex_pc_i + ex_imm_i;
  assign w_pc_4     = ex_pc_i + XLEN'(4);
  assign w_rs1_imm  = ex_rs1_i + ex_imm_i;
  assign w_jalr_tgt = {w_rs1_imm[XLEN-1:1], 1'b0};

  always_comb begin
    w_next_pc = w_pc_4;
    if (ex_is_jal_i) begin
      w_next_pc = w_pc_imm;
    end else if (ex_is_jalr_i) begin
      w_next_pc = w_jalr_tgt;
    end else if (ex_is_branch_i && w_cond) begin
      w_next_pc = w_pc_imm;
    end
  end

  assign w_mispred = w_accept && (w_next_pc != ex_pred_addr_i);

  // --------------------------------------------------------------------------
  // Flush FSM: next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (w_mispred) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = C_FC_LOAD;
        end
      end
      ST_FLUSH: begin
        // Leaving on a count of 1 keeps flush high for exactly C_FC_LOAD cycles.
        if (flush_cnt_q <= 3'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Result registers and statistics.
  // --------------------------------------------------------------------------
  always_comb begin
    taken_d   = w_mispred;
    addr_d    = addr_q;
    link_d    = link_q;
    illegal_d = w_accept && ex_is_branch_i && w_reserved;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;

    if (w_mispred) begin
      addr_d = w_next_pc;
    end
    if (w_accept && (ex_is_jal_i || ex_is_jalr_i)) begin
      link_d = w_pc_4;
    end
    // Counters stick at all-ones instead of wrapping.
    if (w_accept && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (w_mispred && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      taken_q     <= 1'b0;
      addr_q      <= '0;
      link_q      <= '0;
      illegal_q   <= 1'b0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      taken_q     <= taken_d;
      addr_q      <= addr_d;
      link_q      <= link_d;
      illegal_q   <= illegal_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign branch_taken_o  = taken_q;
  assign branch_addr_o   = addr_q;
  assign flush_o         = (state_q == ST_FLUSH);
  assign link_addr_o     = link_q;
  assign illegal_br_o    = illegal_q;
  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mis_cnt_q;

endmodule
`default_nettype wire
